// File: rtl/vme_cmd_initiator_pkg.sv
// Shared definitions for the VME device-bus command initiator:
// FSM encoding, bus widths and the status-device command codes.
package vme_cmd_initiator_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STRB    = 3'd2,
        RELEASE = 3'd3,
        FINISH  = 3'd4
    } state_t;

    // Command codes understood by the status/version responder
    localparam logic [CMD_W-1:0] VERS  = 10'd0;
    localparam logic [CMD_W-1:0] DATE  = 10'd1;
    localparam logic [CMD_W-1:0] STAT1 = 10'd2;
    localparam logic [CMD_W-1:0] STAT2 = 10'd3;

endpackage

// File: rtl/vme_cmd_initiator.sv
// Issues one read or write cycle at a time on the on-board VME device bus and
// reports completion or timeout back to the address-decode logic.
module vme_cmd_initiator
    import vme_cmd_initiator_pkg::*;
#(
    parameter int NDEV        = 8,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic              FASTCLK,
    input  logic              RST_B,
    input  logic              REQ,
    input  logic              REQ_WRITE,
    input  logic [NDEV-1:0]   REQ_DEV,
    input  logic [CMD_W-1:0]  REQ_CMD,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              TIMEOUT,
    output logic [DATA_W-1:0] RDATA,
    output logic              STROBE,
    output logic              WRITE_B,
    output logic [NDEV-1:0]   DEVICE,
    output logic [CMD_W-1:0]  COMMAND,
    output logic [DATA_W-1:0] INDATA,
    input  logic              DTACK_B,
    input  logic [DATA_W-1:0] OUTDATA
);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD   = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ack;

    // Only a driven 0 acknowledges; a floating (pulled-up) or unknown line does not.
    assign ack = (DTACK_B === 1'b0);

    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            state   <= IDLE;
            cnt     <= '0;
            STROBE  <= 1'b0;
            WRITE_B <= 1'b1;
            DEVICE  <= '0;
            COMMAND <= '0;
            INDATA  <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            TIMEOUT <= 1'b0;
            RDATA   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ) begin
                        DEVICE  <= REQ_DEV;
                        COMMAND <= REQ_CMD;
                        INDATA  <= REQ_WDATA;
                        WRITE_B <= ~REQ_WRITE;
                        BUSY    <= 1'b1;
                        TIMEOUT <= 1'b0;
                        cnt     <= SETUP_LOAD;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        STROBE <= 1'b1;
                        cnt    <= TMO_LOAD;
                        state  <= STRB;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STRB: begin
                    // An acknowledge on the last counted cycle still completes normally.
                    if (ack) begin
                        if (WRITE_B) begin
                            RDATA <= OUTDATA;
                        end
                        STROBE  <= 1'b0;
                        TIMEOUT <= 1'b0;
                        cnt     <= TMO_LOAD;
                        state   <= RELEASE;
                    end else if (cnt == '0) begin
                        STROBE  <= 1'b0;
                        TIMEOUT <= 1'b1;
                        cnt     <= TMO_LOAD;
                        state   <= RELEASE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    // Hold off until the responder lets go, so its acknowledge
                    // cannot be mistaken for one belonging to the next cycle.
                    if (!ack) begin
                        state <= FINISH;
                    end else if (cnt == '0) begin
                        TIMEOUT <= 1'b1;
                        state   <= FINISH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FINISH: begin
                    DONE    <= 1'b1;
                    BUSY    <= 1'b0;
                    DEVICE  <= '0;
                    WRITE_B <= 1'b1;
                    cnt     <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vme_cmd_initiator.sv
// Bench for vme_cmd_initiator: status responder on DEVICE[0], a programmable-latency
// device on DEVICE[1], nothing on the other selects.
module tb_vme_cmd_initiator;

    localparam int NDEV  = 8;
    localparam int SETUP = 2;
    localparam int TO    = 255;

    logic        FASTCLK = 1'b0;
    logic        RST_B;
    logic        REQ;
    logic        REQ_WRITE;
    logic [7:0]  REQ_DEV;
    logic [9:0]  REQ_CMD;
    logic [15:0] REQ_WDATA;
    logic        BUSY, DONE, TIMEOUT, STROBE, WRITE_B;
    logic [15:0] RDATA, INDATA, OUTDATA;
    logic [7:0]  DEVICE;
    logic [9:0]  COMMAND;
    logic        DTACK_B;

    int asserts = 0;
    int fails   = 0;
    logic [15:0] exp_rdata;

    always #5 FASTCLK = ~FASTCLK;

    vme_cmd_initiator #(
        .NDEV(NDEV), .SETUP_CYC(SETUP), .TIMEOUT_CYC(TO), .CNT_W(8)
    ) dut (
        .FASTCLK(FASTCLK), .RST_B(RST_B), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
        .REQ_DEV(REQ_DEV), .REQ_CMD(REQ_CMD), .REQ_WDATA(REQ_WDATA),
        .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT), .RDATA(RDATA),
        .STROBE(STROBE), .WRITE_B(WRITE_B), .DEVICE(DEVICE), .COMMAND(COMMAND),
        .INDATA(INDATA), .DTACK_B(DTACK_B), .OUTDATA(OUTDATA)
    );

    function automatic logic [15:0] ref_word(input logic [1:0] c);
        case (c)
            2'd0:    ref_word = 16'h7E16;
            2'd1:    ref_word = 16'h37D0;
            2'd2:    ref_word = 16'h0C3A;
            default: ref_word = 16'h5A01;
        endcase
    endfunction

    // Status responder: registered acknowledge for commands 0..3
    logic        st_ack_b;
    logic [15:0] st_data;
    always @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            st_ack_b <= 1'b1;
            st_data  <= '0;
        end else if (STROBE && DEVICE[0] && COMMAND < 10'd4) begin
            st_ack_b <= 1'b0;
            st_data  <= ref_word(COMMAND[1:0]);
        end else begin
            st_ack_b <= 1'b1;
            st_data  <= '0;
        end
    end

    // Generic device: acknowledge visible at the gen_d-th edge after STROBE rises (0 = never)
    int          gen_d = 0;
    int          gen_cnt;
    logic [15:0] gen_word = '0;
    logic        gen_ack_b;
    always @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            gen_ack_b <= 1'b1;
            gen_cnt   <= 0;
        end else if (STROBE && DEVICE[1]) begin
            gen_cnt <= gen_cnt + 1;
            if (gen_d != 0 && gen_cnt + 1 >= gen_d - 1) gen_ack_b <= 1'b0;
        end else begin
            gen_cnt   <= 0;
            gen_ack_b <= 1'b1;
        end
    end

    assign DTACK_B = st_ack_b & gen_ack_b;
    assign OUTDATA = !st_ack_b ? st_data : (!gen_ack_b ? gen_word : 16'h0000);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        asserts++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_txn(input logic wr, input logic [7:0] dev, input logic [9:0] cmd,
                           input logic [15:0] wdata, input int extra_req_at);
        int d, h, exp_done, edges, strb_cnt, done_cnt, first_done;
        logic exp_to, done_to, done_dtack, done_wb;
        logic [7:0] done_dev;
        logic [9:0] done_cmd;
        logic [15:0] rd_word;
        logic stable_ok, busy_ok;
        // Expected behaviour from the bus protocol: setup, strobe window, release, finish
        d = 0;
        rd_word = '0;
        if (dev == 8'h01 && cmd < 10'd4) begin
            d = 2;
            rd_word = ref_word(cmd[1:0]);
        end else if (dev == 8'h02 && gen_d != 0) begin
            d = gen_d;
            rd_word = gen_word;
        end
        exp_to   = (d == 0);
        h        = exp_to ? TO : d;
        exp_done = SETUP + h + (exp_to ? 1 : 2) + 1;
        if (!wr && !exp_to) exp_rdata = rd_word;

        @(posedge FASTCLK); #1;
        REQ = 1'b1; REQ_WRITE = wr; REQ_DEV = dev; REQ_CMD = cmd; REQ_WDATA = wdata;
        @(posedge FASTCLK); #1;
        REQ = 1'b0;
        chk("busy_on_accept", {31'd0, BUSY}, 32'd1);
        edges = 0; strb_cnt = 0; done_cnt = 0; first_done = -1;
        stable_ok = 1'b1; busy_ok = 1'b1;
        done_to = 1'bx; done_dtack = 1'bx; done_wb = 1'bx; done_dev = 'x; done_cmd = 'x;
        while (edges < exp_done + 12) begin
            @(posedge FASTCLK); #1;
            edges++;
            if (STROBE) strb_cnt++;
            if (DONE) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = edges;
                    done_to = TIMEOUT; done_dtack = DTACK_B; done_wb = WRITE_B;
                    done_dev = DEVICE; done_cmd = COMMAND;
                end
            end else if (first_done < 0) begin
                if (BUSY !== 1'b1) busy_ok = 1'b0;
                if (DEVICE !== dev || COMMAND !== cmd || WRITE_B !== ~wr || INDATA !== wdata)
                    stable_ok = 1'b0;
            end
            if (extra_req_at != 0 && edges == extra_req_at) begin
                REQ = 1'b1; REQ_WRITE = ~wr; REQ_DEV = ~dev; REQ_CMD = ~cmd; REQ_WDATA = ~wdata;
            end else begin
                REQ = 1'b0;
            end
        end
        REQ = 1'b0;
        chk("done_latency", first_done, exp_done);
        chk("done_count", done_cnt, 1);
        chk("strobe_cycles", strb_cnt, h);
        chk("timeout_flag", {31'd0, done_to}, {31'd0, exp_to});
        chk("rdata", {16'd0, RDATA}, {16'd0, exp_rdata});
        chk("dtack_released_at_done", {31'd0, done_dtack}, 32'd1);
        chk("finish_device", {24'd0, done_dev}, 32'd0);
        chk("finish_write_b", {31'd0, done_wb}, 32'd1);
        chk("finish_command_hold", {22'd0, done_cmd}, {22'd0, cmd});
        chk("addr_data_stable", {31'd0, stable_ok}, 32'd1);
        chk("busy_held", {31'd0, busy_ok}, 32'd1);
        chk("busy_after_done", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        int r;
        logic [7:0] dev;
        RST_B = 1'b0; REQ = 1'b0; REQ_WRITE = 1'b0; REQ_DEV = '0; REQ_CMD = '0; REQ_WDATA = '0;
        exp_rdata = 16'h0000;
        repeat (3) @(posedge FASTCLK);
        #1;
        chk("rst_strobe", {31'd0, STROBE}, 32'd0);
        chk("rst_write_b", {31'd0, WRITE_B}, 32'd1);
        chk("rst_device", {24'd0, DEVICE}, 32'd0);
        chk("rst_command", {22'd0, COMMAND}, 32'd0);
        chk("rst_indata", {16'd0, INDATA}, 32'd0);
        chk("rst_busy_done_to", {29'd0, BUSY, DONE, TIMEOUT}, 32'd0);
        chk("rst_rdata", {16'd0, RDATA}, 32'd0);
        @(negedge FASTCLK);
        RST_B = 1'b1;

        run_txn(1'b0, 8'h01, 10'd0, 16'h0000, 0);
        run_txn(1'b0, 8'h01, 10'd1, 16'h0000, 0);
        run_txn(1'b0, 8'h01, 10'd5, 16'h0000, 0);
        gen_d = 3;
        run_txn(1'b1, 8'h02, 10'd7, 16'hA5C3, 0);
        run_txn(1'b0, 8'h01, 10'd2, 16'h0000, 2);
        run_txn(1'b0, 8'h00, 10'd0, 16'h0000, 0);

        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(0, 3));
            dev = (r == 0) ? 8'h01 : (r == 3) ? 8'h04 : 8'h02;
            r = int'($urandom_range(1, 6));
            gen_d = (r == 1) ? 0 : r;
            gen_word = 16'($urandom);
            run_txn(1'($urandom), dev, 10'($urandom_range(0, 7)), 16'($urandom), 0);
        end

        // Asynchronous reset in the middle of a strobe window
        gen_d = 0;
        @(posedge FASTCLK); #1;
        REQ = 1'b1; REQ_WRITE = 1'b0; REQ_DEV = 8'h02; REQ_CMD = 10'd1;
        @(posedge FASTCLK); #1;
        REQ = 1'b0;
        repeat (5) @(posedge FASTCLK);
        #1;
        chk("pre_reset_strobe", {31'd0, STROBE}, 32'd1);
        #2;
        RST_B = 1'b0;
        #1;
        chk("async_rst_strobe", {31'd0, STROBE}, 32'd0);
        chk("async_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("async_rst_device", {24'd0, DEVICE}, 32'd0);
        exp_rdata = 16'h0000;
        chk("async_rst_rdata", {16'd0, RDATA}, 32'd0);
        repeat (2) @(posedge FASTCLK);
        @(negedge FASTCLK);
        RST_B = 1'b1;
        run_txn(1'b0, 8'h01, 10'd0, 16'h0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
